ccff_chain_loader: RTL
======================

Name: ccff_chain_loader

Overview:
- Upstream stage of the configuration-chain flip-flop (CCFF) chain that runs through the I/O and logic tiles.
- Accepts bitstream words over a valid/ready stream, serializes them onto the chain head and gates the chain shift.
- After loading, it recirculates the chain once and checks a CRC-16 of the bits seen on the chain tail against the loaded bits, then asserts cfg_done to release the fabric.

Parameters:
- CHAIN_LEN, 128, number of CCFF bits in the chain; must be ≥ 2.
- WORD_W, 8, width of the input bitstream word; must be ≥ 1.
- VERIFY_EN, 1, 1 = recirculate-and-CRC verify pass; 0 = go straight to DONE after load.

Ports:
- prog_clk  input  1  configuration clock; the chain flops share this clock.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load.
- s_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts s_data this cycle.
- ccff_head  output  1  serial data into the chain head.
- ccff_tail  input  1  serial data from the chain tail.
- chain_shift_en  output  1  enable to the external clock gate; the chain shifts on a prog_clk edge only when this is 1.
- busy  output  1  high in LOAD or VERIFY.
- cfg_done  output  1  configuration complete and verified.
- cfg_error  output  1  verify CRC mismatch.

Behaviour:
- Clocking and reset
  - Single clock domain prog_clk.
  - Reset is asynchronous and active-low (prog_reset_n).
  - Reset values: state IDLE; s_ready, ccff_head, chain_shift_en, busy, cfg_done, cfg_error all 0; counters 0; both CRCs 0xFFFF.
- State IDLE
  - Outputs 0, except cfg_done/cfg_error, which hold their last value.
  - start → LOAD. Entering LOAD clears cfg_done, cfg_error, bit_cnt and both CRCs.
  - start in any state other than IDLE/DONE/ERROR is ignored.
- State LOAD
  - Holds a WORD_W shift register and a "word held" flag.
  - s_ready = 1 when no word is held, or when the held word's last bit is being shifted this cycle (back-to-back words give no bubble).
  - Handshake: a word is taken when s_valid & s_ready.
  - Per cycle with a word held:
    - ccff_head = current bit; chain_shift_en = 1.
    - bit_cnt++.
    - crc_tx updated with the bit (CRC-16-CCITT, poly 0x1021, serial, MSB-style feedback).
  - With no word held: chain_shift_en = 0 and the chain does not move (stall-safe); ccff_head holds its value.
  - When bit_cnt reaches CHAIN_LEN (after the CHAIN_LEN-th shift), the remaining bits of the partial word are discarded.
  - Next state: VERIFY if VERIFY_EN, else DONE.
  - s_ready = 0 from that cycle onward.
- State VERIFY (exactly CHAIN_LEN cycles, no stalls)
  - ccff_head = ccff_tail (recirculate); chain_shift_en = 1.
  - crc_rx updated with ccff_tail each cycle.
  - After CHAIN_LEN cycles the chain holds its original contents.
  - On exit: crc_rx == crc_tx → DONE, else ERROR.
- State DONE
  - cfg_done = 1 (registered, asserted the cycle after the final shift); chain_shift_en = 0.
  - cfg_done stays high until reset or the next start.
- State ERROR
  - cfg_error = 1; cfg_done = 0; chain frozen.
  - start retries the load.
- Bit counter
  - Width $clog2(CHAIN_LEN+1); never wraps.
  - Verify counter is a separate counter of the same width.
- Boundary cases
  - CHAIN_LEN a multiple of WORD_W: no discard.
  - Extra s_valid words after the load completes are not accepted (s_ready = 0).
  - start in the same cycle as reset deassertion: ignored.
  - Reset mid-LOAD/VERIFY: returns to IDLE immediately with cfg_done = 0. The chain contents are undefined and the fabric stays held by cfg_done = 0.
  - start and s_valid in the same cycle: the word is not accepted until LOAD (the next cycle).

Decomposition:
- Shared package ccff_cfg_pkg:
  - state enum (IDLE, LOAD, VERIFY, DONE, ERROR);
  - CRC16_POLY = 16'h1021 and CRC16_INIT = 16'hFFFF;
  - function crc16_step(crc, bit).
- One sub-module, ccff_serializer: the WORD_W piso register with the held flag and s_ready generation.
- The top level holds the FSM, the counters and both CRCs.

Test Plan:
- Basic load (CHAIN_LEN=16, WORD_W=8, VERIFY_EN=1, behavioural 16-flop chain model):
  - Stimulus: start, then words 0xA5, 0x3C back-to-back.
  - Expected: 16 shift cycles with head bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; then 16 verify cycles; cfg_done=1 at cycle 34 after start; chain model holds 0x3CA5.
- Stall:
  - Stimulus: s_valid deasserted for 5 cycles between the two words.
  - Expected: chain_shift_en=0 for exactly those 5 cycles; final chain contents and cfg_done identical to the basic load.
- Partial last word (CHAIN_LEN=12):
  - Stimulus: words 0xFF, 0x0F.
  - Expected: only 12 bits shifted; the upper nibble of the second word is discarded; s_ready=0 after; cfg_done=1.
- Verify fail:
  - Stimulus: chain model forces one bit flip on ccff_tail during VERIFY.
  - Expected: cfg_error=1, cfg_done=0, state ERROR; a following start with a clean chain gives cfg_done=1, cfg_error=0.
- Reset mid-load:
  - Stimulus: prog_reset_n low asynchronously after 7 shifts.
  - Expected: all outputs 0 within the same cycle; a fresh start completes normally.
- VERIFY_EN=0:
  - Expected: cfg_done=1 the cycle after the 16th shift; chain_shift_en never high after load.

Source files
------------

// File: rtl/ccff_cfg_pkg.sv
// Shared types and CRC helper for the configuration-chain loader.
// CRC-16-CCITT is processed one bit at a time, MSB-style feedback.
package ccff_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        VERIFY = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the chain loader.
// A word transfers on a prog_clk edge where s_valid & s_ready are both high;
// the source holds s_data stable while s_valid is high and s_ready is low.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ccff_serializer.sv
// Parallel-in/serial-out word register feeding the chain head, LSB first.
// Accepts the next word while the last bit of the current one is shifted out.
module ccff_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,      // loader is in LOAD
    input  logic              last_shift,  // this shift, if any, fills the chain
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              held,
    output logic              cur_bit
);
    localparam int IW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sh_reg;
    logic [IW-1:0]     idx;
    logic              word_end;
    logic              take;

    assign word_end = held && (idx == IW'(WORD_W - 1));
    // No new word once the chain is full, even if a word boundary lines up with it.
    assign s_ready  = active && !(held && last_shift) && (!held || word_end);
    assign take     = s_valid && s_ready;
    assign cur_bit  = sh_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg <= '0;
            held   <= 1'b0;
            idx    <= '0;
        end else if (!active) begin
            held <= 1'b0;
            idx  <= '0;
        end else if (take) begin
            sh_reg <= s_data;
            held   <= 1'b1;
            idx    <= '0;
        end else if (held) begin
            if (word_end) begin
                held <= 1'b0;
            end else begin
                sh_reg <= sh_reg >> 1;
                idx    <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a bitstream into the CCFF chain, optionally recirculates it once to
// compare a CRC of the tail bits against the loaded bits, then releases the fabric.
module ccff_chain_loader
    import ccff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 8,
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                start,
    ccff_chain_loader_if.slave  s,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                chain_shift_en,
    output logic                busy,
    output logic                cfg_done,
    output logic                cfg_error,
    output state_e              state_dbg
);
    localparam int CW = $clog2(CHAIN_LEN + 1);

    state_e        state;
    logic          armed;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] ver_cnt;
    logic [15:0]   crc_tx;
    logic [15:0]   crc_rx;
    logic [15:0]   crc_rx_next;
    logic          head_q;
    logic          held;
    logic          cur_bit;
    logic          last_shift;
    logic          load_shift;
    logic          start_ok;

    ccff_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk        (prog_clk),
        .rst_n      (prog_reset_n),
        .active     (state == LOAD),
        .last_shift (last_shift),
        .s_data     (s.s_data),
        .s_valid    (s.s_valid),
        .s_ready    (s.s_ready),
        .held       (held),
        .cur_bit    (cur_bit)
    );

    assign last_shift     = (bit_cnt == CW'(CHAIN_LEN - 1));
    assign load_shift     = (state == LOAD) && held;
    // armed masks a start seen on the first edge after reset release.
    assign start_ok       = start && armed;
    assign crc_rx_next    = crc16_step(crc_rx, ccff_tail);
    assign chain_shift_en = load_shift || (state == VERIFY);
    assign state_dbg      = state;

    always_comb begin
        ccff_head = 1'b0;
        case (state)
            LOAD:    ccff_head = held ? cur_bit : head_q;
            VERIFY:  ccff_head = ccff_tail;
            default: ccff_head = 1'b0;
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            ver_cnt   <= '0;
            crc_tx    <= CRC16_INIT;
            crc_rx    <= CRC16_INIT;
            head_q    <= 1'b0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_ok) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                        bit_cnt   <= '0;
                        ver_cnt   <= '0;
                        crc_tx    <= CRC16_INIT;
                        crc_rx    <= CRC16_INIT;
                        head_q    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (held) begin
                        head_q  <= cur_bit;
                        bit_cnt <= bit_cnt + 1'b1;
                        crc_tx  <= crc16_step(crc_tx, cur_bit);
                        if (last_shift) begin
                            if (VERIFY_EN) begin
                                state <= VERIFY;
                            end else begin
                                state    <= DONE;
                                busy     <= 1'b0;
                                cfg_done <= 1'b1;
                            end
                        end
                    end
                end
                VERIFY: begin
                    crc_rx  <= crc_rx_next;
                    ver_cnt <= ver_cnt + 1'b1;
                    // The final tail bit is folded in before the compare.
                    if (ver_cnt == CW'(CHAIN_LEN - 1)) begin
                        busy <= 1'b0;
                        if (crc_rx_next == crc_tx) begin
                            state    <= DONE;
                            cfg_done <= 1'b1;
                        end else begin
                            state     <= ERROR;
                            cfg_error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
